// File: rtl/eq_vector_checker.sv
// Stimulus/response stage for boolean compare kernels: drives a pseudo-random
// a/b stream, aligns the expected a==b to the DUT latency and scores y.
module eq_vector_checker #(
  parameter int          WIDTH   = 8,
  parameter int          LATENCY = 0,
  parameter int          NUM_VEC = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
  localparam logic [2:0]  DRAIN_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  state_t           state;
  state_t           state_next;
  logic [15:0]      lfsr;
  logic [15:0]      vec_idx;
  logic [2:0]       drain_cnt;
  logic             load_first;
  logic             load_next;
  logic             run_end;
  logic [15:0]      src;
  logic             odd;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic             cur_valid;
  logic             cur_exp;
  logic             chk_valid;
  logic             chk_exp;
  logic [15:0]      chk_idx;
  logic             mismatch;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    run_end    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          load_first = 1'b1;
        end
      end
      S_RUN: begin
        if (vec_idx == LAST_IDX) begin
          run_end    = 1'b1;
          state_next = (LATENCY == 0) ? S_DONE : S_DRAIN;
        end else begin
          load_next = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == 3'd0) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Vector 0 always comes from SEED, so a restart from DONE replays the stream.
  assign src   = load_first ? SEED : lfsr;
  assign odd   = ~load_first & ~vec_idx[0];
  assign vec_a = src[WIDTH-1:0];
  assign vec_b = odd ? src[15 -: WIDTH] : vec_a;

  always_ff @(posedge clock) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      lfsr      <= SEED;
      vec_idx   <= '0;
      cur_valid <= 1'b0;
      cur_exp   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      cur_valid <= load_first | load_next;
      if (load_first | load_next) begin
        a       <= vec_a;
        b       <= vec_b;
        cur_exp <= (vec_a == vec_b);
        lfsr    <= lfsr_step(src);
        vec_idx <= load_first ? 16'd0 : vec_idx + 16'd1;
      end
      if (run_end)
        drain_cnt <= DRAIN_INIT;
      else if (state == S_DRAIN && drain_cnt != 3'd0)
        drain_cnt <= drain_cnt - 3'd1;
    end
  end

  // Expected-result alignment: LATENCY stages of {valid, exp, index}.
  if (LATENCY == 0) begin : g_no_delay
    assign chk_valid = cur_valid;
    assign chk_exp   = cur_exp;
    assign chk_idx   = vec_idx;
  end else begin : g_delay
    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] e_q;
    logic [15:0]        i_q [LATENCY];

    always_ff @(posedge clock) begin
      if (reset) v_q <= '0;
      else begin
        v_q[0] <= cur_valid;
        for (int s = 1; s < LATENCY; s++) v_q[s] <= v_q[s-1];
      end
    end

    // NOTE: payload stages carry no reset; the cleared valid bits already
    // stop stale data from ever being scored.
    always_ff @(posedge clock) begin
      e_q[0] <= cur_exp;
      i_q[0] <= vec_idx;
      for (int s = 1; s < LATENCY; s++) begin
        e_q[s] <= e_q[s-1];
        i_q[s] <= i_q[s-1];
      end
    end

    assign chk_valid = v_q[LATENCY-1];
    assign chk_exp   = e_q[LATENCY-1];
    assign chk_idx   = i_q[LATENCY-1];
  end

  assign mismatch = busy & chk_valid & (y != chk_exp);

  always_ff @(posedge clock) begin
    if (reset) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (load_first) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (err_count == 16'd0)    first_fail <= chk_idx;
    end
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);
  assign fail = done & (err_count != 16'd0);

endmodule

// File: doc/eq_vector_checker.md
Name: eq_vector_checker

Overview:
- Self-checking stimulus/response stage for CI benches of compiled boolean-output compare kernels such as eq_b_i8_i8.
- Sits upstream of the DUT, driving operands a/b, and downstream of it, sampling y.
- Generates a pseudo-random vector stream with forced-equal vectors and computes the expected a==b.
- Aligns the expected result to the DUT latency and reports pass/fail, error count and first failing index.

Parameters:
WIDTH, 8, operand width in bits (must be 1..16)
LATENCY, 0, DUT latency in cycles from operands to y (0..7)
NUM_VEC, 8, vectors issued per run (1..65535)
SEED, 16'hACE1, LFSR seed (nonzero)

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  begin a run; sampled only in IDLE
a  output  WIDTH  operand A to DUT, registered
b  output  WIDTH  operand B to DUT, registered
y  input  1  DUT result
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE, held until next start or reset
fail  output  1  done & (err_count != 0)
err_count  output  16  mismatches, saturating at 16'hFFFF
first_fail  output  16  index of first mismatching vector; 0 if none

Behaviour:
- Reset (synchronous, wins over every other event, including mid-run):
  - State returns to IDLE.
  - a, b, err_count, first_fail, busy and done clear to 0.
  - LFSR reloads SEED.
  - Expected-pipeline valid bits clear.
- LFSR is 16-bit Fibonacci:
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances once per issued vector.
- Vector k:
  - a = l[WIDTH-1:0].
  - b = a if k is even; otherwise b = l[15:16-WIDTH].
  - exp = (a == b).
- States:
  - IDLE: on start, the same edge loads vector 0 onto a/b, clears err_count/first_fail/done and enters RUN. start is ignored in other states.
  - RUN: each edge loads the next vector. The edge that would load vector NUM_VEC instead holds a/b and enters DRAIN, or enters DONE directly if LATENCY == 0.
  - DRAIN: stays LATENCY cycles so the last vector is checked, then enters DONE.
  - DONE: done = 1. On start, behaves as IDLE (new run, LFSR restarts from SEED).
- Check alignment:
  - Vector k occupies a/b during cycle k after RUN entry.
  - exp and a valid bit enter a LATENCY-deep shift pipeline; LATENCY = 0 means compare in the same cycle.
  - y is compared against exp at the edge ending cycle k+LATENCY.
  - Mismatch with valid = 1: err_count increments; first_fail is captured on the first mismatch only.
  - No comparisons occur in IDLE or DONE; y there is don't-care.
- Timing: done rises exactly NUM_VEC + LATENCY edges after the edge that samples start.
- NUM_VEC = 1: RUN lasts one cycle.
- err_count saturates and never wraps.
- start held high continuously: a new run starts immediately after each DONE cycle.

Test Plan:
- Golden combinational DUT (y = a == b), LATENCY=0, NUM_VEC=8, SEED=16'hACE1:
  - vector 0 is a=b=8'hE1; vector 1 is a=8'hC3, b=8'h59.
  - done after 8 edges; fail=0, err_count=0.
- y stuck at 1, same config -> odd vectors fail: err_count=4, first_fail=1, fail=1.
- y stuck at 0 -> even vectors fail: err_count=4, first_fail=0, fail=1.
- DUT registered twice (LATENCY=2), golden logic:
  - busy for 10 cycles, done on the 10th edge, err_count=0.
  - Same DUT with LATENCY=0 configured -> err_count nonzero, fail=1.
- Reset asserted at RUN cycle 3:
  - next cycle: IDLE, a=b=0, err_count=0, done=0.
  - a subsequent start replays vector 0 = 8'hE1/8'hE1.
- start pulsed during RUN is ignored, and the run length is unchanged. start in DONE restarts with err_count cleared and an identical vector sequence.
